// File: rtl/typed_burst_accum.sv
// Burst accumulator: sums BURST_LEN typed beats and XOR-folds a checksum word,
// then holds the result on an output handshake until it is consumed.
module typed_burst_accum #(
  parameter int DATA_W    = 32,
  parameter int WORD_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  input  logic [7:0]        packed_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [WORD_W-1:0] unpacked_data_out,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN);

  // Tag word is {(payload+1) low byte, tag}, resized to WORD_W (zero-extend or keep low bits).
  function automatic logic [WORD_W-1:0] fold_word(input logic [DATA_W-1:0] v,
                                                  input logic [7:0]        tag);
    logic [DATA_W-1:0]   inc;
    logic [WORD_W+15:0]  ext;
    inc = v + DATA_W'(1);
    ext = {{WORD_W{1'b0}}, inc[7:0], tag};
    return ext[WORD_W-1:0] ^ v[WORD_W-1:0];
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc;
  logic [WORD_W-1:0] xsum;

  logic              accept;
  logic              first;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] acc_next;
  logic [WORD_W-1:0] xsum_next;
  logic              last_beat;

  assign accept    = in_valid && in_ready;
  assign first     = (state == IDLE);
  assign cnt_next  = (first ? '0 : count) + CNT_W'(1);
  assign acc_next  = (first ? '0 : acc) + in_val;
  assign xsum_next = (first ? '0 : xsum) ^ fold_word(in_val, packed_data);
  assign last_beat = (cnt_next == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = last_beat ? DONE : RUNNING;
        RUNNING: if (accept && last_beat) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
  end

  // Accumulation and result capture; the result registers load only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count             <= '0;
      acc               <= '0;
      xsum              <= '0;
      out_val           <= '0;
      unpacked_data_out <= '0;
    end else if (abort) begin
      count <= '0;
      acc   <= '0;
      xsum  <= '0;
    end else if (accept) begin
      count <= cnt_next;
      acc   <= acc_next;
      xsum  <= xsum_next;
      if (last_beat) begin
        out_val           <= acc_next;
        unpacked_data_out <= xsum_next;
      end
    end else if (state == DONE && out_ready) begin
      count <= '0;
      acc   <= '0;
      xsum  <= '0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_typed_burst_accum.sv
// Directed bench for typed_burst_accum: table of bursts plus hand-written
// sequences for gaps, backpressure, abort, async reset and a narrow variant.
module tb_typed_burst_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_val;
  logic [7:0]  packed_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
  logic [15:0] unpacked_data_out;
  logic [1:0]  state_o;

  logic        b_abort;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_val;
  logic [7:0]  b_packed_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_val;
  logic [7:0]  b_unpacked_data_out;
  logic [1:0]  b_state_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  typed_burst_accum dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .packed_data(packed_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .unpacked_data_out(unpacked_data_out), .state_o(state_o)
  );

  typed_burst_accum #(.DATA_W(8), .WORD_W(8), .BURST_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .abort(b_abort),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_val(b_in_val), .packed_data(b_packed_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_val(b_out_val),
    .unpacked_data_out(b_unpacked_data_out), .state_o(b_state_o)
  );

  typedef struct {
    logic [3:0][31:0] v;
    logic [3:0][7:0]  pd;
    logic [31:0]      sum;
    logic [15:0]      x;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Presents four back-to-back beats from the negedge, then consumes the result.
  task automatic run_vec(input vec_t t, input string tag);
    for (int i = 0; i < 4; i++) begin
      in_valid    = 1'b1;
      in_val      = t.v[i];
      packed_data = t.pd[i];
      @(negedge clk);
      check({tag, "_state"}, 64'(state_o), (i == 3) ? 64'd2 : 64'd1);
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_sum"},       64'(out_val),   64'(t.sum));
    check({tag, "_xsum"},      64'(unpacked_data_out), 64'(t.x));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_state"}, 64'(state_o),   64'd0);
    check({tag, "_idle_ovld"},  64'(out_valid), 64'd0);
  endtask

  initial begin
    vecs[0].v = {32'd4, 32'd3, 32'd2, 32'd1};
    vecs[0].pd = {8'h40, 8'h30, 8'h20, 8'h10};
    vecs[0].sum = 32'd10;        vecs[0].x = 16'h0044;
    vecs[1].v = {4{32'hFFFF_FFFF}};
    vecs[1].pd = {4{8'h00}};
    vecs[1].sum = 32'hFFFF_FFFC; vecs[1].x = 16'h0000;
    vecs[2].v = {32'h8000_0000, 32'h8000_0000, 32'h0002_0000, 32'h0001_0000};
    vecs[2].pd = {8'h00, 8'h00, 8'h01, 8'hFF};
    vecs[2].sum = 32'h0003_0000; vecs[2].x = 16'h00FE;
    vecs[3].v = {32'h0, 32'h0, 32'h0000_0100, 32'h0000_00FF};
    vecs[3].pd = {8'h00, 8'h00, 8'h00, 8'h55};
    vecs[3].sum = 32'h0000_01FF; vecs[3].x = 16'h00AA;

    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_val = '0; packed_data = '0; out_ready = 1'b0;
    b_abort = 1'b0; b_in_valid = 1'b0; b_in_val = '0; b_packed_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_state",     64'(state_o),           64'd0);
    check("rst_in_ready",  64'(in_ready),          64'd1);
    check("rst_out_valid", 64'(out_valid),         64'd0);
    check("rst_out_val",   64'(out_val),           64'd0);
    check("rst_xsum",      64'(unpacked_data_out), 64'd0);

    for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    check("idle_hold_val", 64'(out_val), 64'(vecs[3].sum));

    // Gapped beats, then backpressure with a beat offered during DONE.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_val = vecs[0].v[i]; packed_data = vecs[0].pd[i];
      @(negedge clk);
      in_valid = 1'b0; in_val = 32'h1234_5678; packed_data = 8'hEE;
      if (i < 3) begin
        @(negedge clk);
        check("gap_hold_state", 64'(state_o), 64'd1);
      end
    end
    in_valid = 1'b1; in_val = 32'h99; packed_data = 8'h99;
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready",  64'(in_ready),          64'd0);
      check("bp_out_valid", 64'(out_valid),         64'd1);
      check("bp_sum",       64'(out_val),           64'd10);
      check("bp_xsum",      64'(unpacked_data_out), 64'h44);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_state", 64'(state_o), 64'd0);
    check("bp_release_ovld",  64'(out_valid), 64'd0);

    // Abort on the third beat.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_val = vecs[0].v[i]; packed_data = vecs[0].pd[i];
      abort = (i == 2);
      @(negedge clk);
    end
    abort = 1'b0; in_valid = 1'b0;
    check("abort_state", 64'(state_o),   64'd0);
    check("abort_ovld",  64'(out_valid), 64'd0);
    @(negedge clk);
    check("abort_stay_idle", 64'(out_valid), 64'd0);
    run_vec(vecs[0], "post_abort");

    // Async reset while in DONE, between clock edges.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_val = vecs[0].v[i]; packed_data = vecs[0].pd[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_done", 64'(state_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_ovld",  64'(out_valid),         64'd0);
    check("arst_val",   64'(out_val),           64'd0);
    check("arst_xsum",  64'(unpacked_data_out), 64'd0);
    check("arst_state", 64'(state_o),           64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_after_state", 64'(state_o), 64'd0);

    // Narrow single-beat variant.
    b_in_valid = 1'b1; b_in_val = 8'hFF; b_packed_data = 8'hAB;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_state",    64'(b_state_o),           64'd2);
    check("b_ovld",     64'(b_out_valid),         64'd1);
    check("b_in_ready", 64'(b_in_ready),          64'd0);
    check("b_sum",      64'(b_out_val),           64'hFF);
    check("b_xsum",     64'(b_unpacked_data_out), 64'h54);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_idle", 64'(b_state_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
